// File: rtl/fifo_sync_pkg.sv
// Shared defaults and width helpers for the synchronous programmable FIFO.
// Used by fifo_sync_prog and fifo_sync_ram (FIFO_SYNC_FWFT_EN mode select lives in the top).
package fifo_sync_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 16;

   // Occupancy spans 0..depth inclusive, so it needs one more code than a pointer.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array for fifo_sync_prog: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the owning FIFO tracks validity through its pointers.
module fifo_sync_ram
   import fifo_sync_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [ptr_width(DEPTH)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic [ptr_width(DEPTH)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]         rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and error pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through dout; otherwise dout is registered.
module fifo_sync_prog
   import fifo_sync_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_ok, rd_ok;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Handshake: wr_en/rd_en are requests sampled on the rising edge. A read is accepted
   // only when the FIFO is non-empty at that edge; a write is accepted when not full or when
   // a read is accepted on the same edge. Rejected requests change no state and raise
   // overflow/underflow for the following cycle.
   always_comb begin
      rd_ok       = 1'b0;
      wr_ok       = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      rd_ok = rd_en && !empty;
      wr_ok = wr_en && (!full || rd_ok);

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (wr_ok && !rd_ok) begin
         count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - CW'(1);
      end

      overflow_d  = wr_en && !wr_ok;
      underflow_d = rd_en && !rd_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_sync_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

`ifdef FIFO_SYNC_FWFT_EN
   // Head entry shown directly; forced to zero while empty so reset clears it immediately.
   assign dout = empty ? '0 : ram_rdata;
`else
   logic [DATA_WIDTH-1:0] dout_q, dout_d;

   always_comb begin
      dout_d = dout_q;
      if (rd_ok) begin
         dout_d = ram_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;
`endif

   assign count        = count_q;
   assign full         = (count_q == FULL_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: doc/fifo_sync_prog.md
FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL expose parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 The block SHALL expose parameter AF_THRESH, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 The block SHALL expose parameter AE_THRESH, default 2, count at or below which almost_empty asserts.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port wr_en  input  1  write request.
REQ-008 Port din  input  DATA_WIDTH  write data.
REQ-009 Port rd_en  input  1  read request (pop).
REQ-010 Port dout  output  DATA_WIDTH  read data.
REQ-011 Port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-012 Port count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-013 Port overflow, underflow  output  1 each  one-cycle pulses on rejected write/read.

Function
REQ-014 A write SHALL be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle).
REQ-015 A read SHALL be accepted when rd_en=1 and empty=0; a write in the same cycle does not make an empty FIFO readable.
REQ-016 count SHALL increment on write-only, decrement on read-only, and hold on both or neither.
REQ-017 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-018 full SHALL equal (count==DEPTH), empty (count==0), almost_full (count>=AF_THRESH), almost_empty (count<=AE_THRESH); all derived from registered count, no combinational path from wr_en/rd_en.
REQ-019 overflow SHALL pulse for exactly the cycle after wr_en=1 is rejected; underflow likewise for rejected rd_en; no state changes on rejection.
REQ-020 Data SHALL leave in exactly the order written; no entry lost or duplicated across wrap-around.

Reset
REQ-021 Asserting rst SHALL immediately clear pointers, count, dout, overflow, underflow to 0, set empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>0).
REQ-022 Reset mid-operation SHALL discard all contents; storage array is not cleared.
REQ-023 The first accepted operation SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro FIFO_SYNC_FWFT_EN SHALL select first-word-fall-through mode.
REQ-025 Without FIFO_SYNC_FWFT_EN: dout is registered, updated with the head entry on the edge that accepts a read (1-cycle latency), and holds its value otherwise.
REQ-026 With FIFO_SYNC_FWFT_EN: dout continuously shows the head entry whenever empty=0 (0-cycle latency), rd_en acknowledges/pops it; dout is don't-care when empty=1.
REQ-027 Flag, count and error behaviour SHALL be identical in both modes.

Structure
REQ-028 Package fifo_sync_pkg SHALL hold default DATA_WIDTH/DEPTH constants and the count/pointer width helper function.
REQ-029 Storage SHALL be a sub-module fifo_sync_ram: 1 write port, 1 read port, synchronous write, asynchronous read; fifo_sync_prog owns pointers, count, flags and dout register.

Verification (DATA_WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-030 Reset then write 11,22,33,44 -> count 1,2,3,4; almost_full at count 3; full at 4; almost_empty clears at count 2.
REQ-031 Fifth write 55 while full -> overflow pulses 1 cycle, count stays 4, later reads return 11,22,33,44.
REQ-032 Read 5 times from full -> dout 11,22,33,44 (1 cycle after each rd_en, non-FWFT); fifth read -> underflow pulse, empty=1, dout holds 44.
REQ-033 Full FIFO with wr_en=rd_en=1, din=AA -> read accepted, write accepted, count stays 4; AA emerges after three further reads.
REQ-034 Empty FIFO with wr_en=rd_en=1, din=BB -> write only, count=1, underflow pulses; 10 write/read cycles wrap pointers with data intact.
REQ-035 rst asserted with count=3 mid-cycle -> flags/count reset immediately without clock edge; FWFT build: dout shows first written value same cycle as empty falls.
